if_inst_queue: RTL and testbench
================================

Name: if_inst_queue

Overview:
- Fetch buffer between ifu and the if/id register; decouples icache/IFU latency from decode stalls.
- Accepts one {pc, inst, trap, prediction tag} entry per cycle from ifu and presents the oldest entry to decode in show-ahead form.
- Drains on redirect (`if_flush_i`).
- Blocks further fetch after a trapping entry, so no younger instruction passes a fault.

Parameters:
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- PTR_W, 2: pointer width, equal to log2(DEPTH).
- NOP_INST, 32'h0000_0013: instruction presented when the queue is empty or flushed.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  ifu entry valid (driven from ~ram_stall_valid_if_o).
- in_ready_o  out  1  queue can accept; feeds the fetch stall.
- in_pc_i  in  32  instruction address from ifu inst_addr_o.
- in_inst_i  in  32  instruction word from ifu inst_data_o.
- in_trap_i  in  `TRAP_LEN  trap bus from ifu trap_bus_o.
- in_pdt_res_i  in  1  branch prediction taken.
- in_pdt_pc_i  in  32  predicted target.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  decode consumes head (= ~id_stall).
- out_pc_o  out  32  head pc.
- out_inst_o  out  32  head instruction.
- out_trap_o  out  `TRAP_LEN  head trap bus.
- out_pdt_res_o  out  1  head prediction taken.
- out_pdt_pc_o  out  32  head predicted target.
- if_flush_i  in  1  redirect; empty the queue.
- count_o  out  PTR_W+1  occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr = wr_ptr = 0, count = 0, trap_block = 0.
  - out_valid_o = 0, in_ready_o = 1.
  - out_pc_o = 0, out_inst_o = NOP_INST, out_trap_o = 0, out_pdt_* = 0.
  - Storage is not reset.
- Handshakes:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - Both take effect on the rising edge.
- in_ready_o = ~trap_block & (count < DEPTH | pop).
  - Push while full is allowed in the same cycle as a pop.
  - in_ready_o is combinational on out_ready_i; it has no path from in_valid_i.
- Pointers:
  - Push writes mem[wr_ptr] and increments wr_ptr; pop increments rd_ptr.
  - Pointers wrap modulo DEPTH.
  - count += push − pop.
- Head presentation (show-ahead):
  - Outputs are taken combinationally from mem[rd_ptr] when count != 0.
  - When count = 0: out_valid_o = 0 and outputs hold the reset values (NOP_INST, zeros).
- Latency: an entry pushed at edge N is visible at the head at the earliest after edge N (1 cycle), unless the optional bypass is enabled.
- Trap blocking:
  - trap_block is set on a push with |in_trap_i = 1.
  - While set, in_ready_o = 0.
  - Cleared when the trapping entry is popped, or on flush.
  - Cleared-by-pop and a new push may occur on the same edge only if the cleared entry is not the pushed one.
- Flush (if_flush_i = 1):
  - Overrides everything at the edge: count = 0, rd_ptr = wr_ptr = 0, trap_block = 0.
  - A same-cycle push is dropped.
  - A same-cycle pop is still reported to decode; decode qualifies it with its own flush.
  - in_ready_o is forced to 0 during the flush cycle.
- Boundaries:
  - Pop on empty: impossible because out_valid_o = 0.
  - Simultaneous push and pop at count = DEPTH: count stays DEPTH.
  - Simultaneous push and pop at count = 1: the head advances to the new entry.
  - Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count = 0, in_valid_i = 1 and no flush, the input entry is forwarded combinationally to out_* with out_valid_o = 1.
  - If out_ready_i = 1, the entry is consumed and not written; count stays 0 (zero-cycle latency).
  - If out_ready_i = 0, the entry is written normally.
  - Trap blocking still applies to a bypassed trapping entry only if it is not consumed.
- Not defined: the queue always imposes 1-cycle latency, as described above.

Test Plan:
- Reset release, no input → out_valid_o = 0, out_inst_o = 32'h0000_0013, in_ready_o = 1, count_o = 0.
- Push pc 0x8000_0000/0x8000_0004/0x8000_0008/0x8000_000C with out_ready_i = 0 → count_o = 4, in_ready_o = 0. Then raise out_ready_i → pops in order; in_ready_o = 1 while popping; pushing 0x8000_0010 simultaneously keeps count_o = 4.
- Continuous push and pop for 3·DEPTH cycles with incrementing pc → output pc sequence is monotonic +4 across pointer wrap, with no loss or duplication.
- Push an entry with the TRAP_INST_PAGE_FAULT bit set at pc 0x8000_1000 → in_ready_o = 0 until that entry pops. The next push is accepted the cycle after the pop, and out_trap_o shows the bit on that entry only.
- With 3 entries queued, assert if_flush_i together with in_valid_i → next cycle count_o = 0, out_valid_o = 0, and the pushed entry is absent.
- IFQ_BYPASS_EN defined, empty queue, push pc 0x8000_2000 with out_ready_i = 1 → out_valid_o = 1 and out_pc_o = 0x8000_2000 in the same cycle, with count_o staying 0. Without the macro, it appears one cycle later with count_o = 1.

Source files
------------

// File: rtl/if_inst_queue.sv
// Fetch queue between the IFU and the IF/ID register: show-ahead FIFO with trap blocking.
// Define IFQ_BYPASS_EN to forward an entry arriving at an empty queue straight to decode.

`ifndef TRAP_LEN
`define TRAP_LEN 16
`endif
`ifndef TRAP_INST_PAGE_FAULT
`define TRAP_INST_PAGE_FAULT 12
`endif

module if_inst_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          in_pc_i,
  input  logic [31:0]          in_inst_i,
  input  logic [`TRAP_LEN-1:0] in_trap_i,
  input  logic                 in_pdt_res_i,
  input  logic [31:0]          in_pdt_pc_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_pc_o,
  output logic [31:0]          out_inst_o,
  output logic [`TRAP_LEN-1:0] out_trap_o,
  output logic                 out_pdt_res_o,
  output logic [31:0]          out_pdt_pc_o,
  input  logic                 if_flush_i,
  output logic [PTR_W:0]       count_o
);

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [`TRAP_LEN-1:0] trap;
    logic                 pdt_res;
    logic [31:0]          pdt_pc;
  } entry_t;

  localparam logic [PTR_W:0] FullCount = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] OneCount  = {{PTR_W{1'b0}}, 1'b1};

  entry_t             mem_q [DEPTH];
  entry_t             in_entry;
  entry_t             head;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               trap_block_q, trap_block_d;
  logic               have_head;
  logic               full;
  logic               pop_mem;
  logic               push;
  logic               wr_en;
  logic               byp_vld;
  logic               byp_take;

  assign in_entry = '{pc:      in_pc_i,
                      inst:    in_inst_i,
                      trap:    in_trap_i,
                      pdt_res: in_pdt_res_i,
                      pdt_pc:  in_pdt_pc_i};

  assign have_head = (count_q != '0);
  assign full      = (count_q == FullCount);
  // Stored-entry pop only; keeps in_ready_o free of any path from in_valid_i.
  assign pop_mem   = have_head & out_ready_i;

  assign in_ready_o = ~trap_block_q & ~if_flush_i & (~full | pop_mem);
  assign push       = in_valid_i & in_ready_o;

`ifdef IFQ_BYPASS_EN
  assign byp_vld  = push & ~have_head;
  assign byp_take = byp_vld & out_ready_i;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never occupies a slot.
  assign wr_en = push & ~byp_take;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  always_comb begin
    head = '{pc: 32'h0, inst: NOP_INST, trap: '0, pdt_res: 1'b0, pdt_pc: 32'h0};
    if (have_head) begin
      head = mem_q[rd_ptr_q];
    end else if (byp_vld) begin
      head = in_entry;
    end
  end

  assign out_valid_o   = have_head | byp_vld;
  assign out_pc_o      = head.pc;
  assign out_inst_o    = head.inst;
  assign out_trap_o    = head.trap;
  assign out_pdt_res_o = head.pdt_res;
  assign out_pdt_pc_o  = head.pdt_pc;
  assign count_o       = count_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    trap_block_d = trap_block_q;
    if (if_flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      trap_block_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_mem) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop_mem};
      // No push is accepted while blocked, so the trapping entry is always the last one.
      if (wr_en && (|in_trap_i)) begin
        trap_block_d = 1'b1;
      end else if (pop_mem && (count_q == OneCount)) begin
        trap_block_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      trap_block_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      trap_block_q <= trap_block_d;
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FullCount);

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed self-checking bench for if_inst_queue: fill/drain, wrap streaming, trap, flush, reset.
// Expectations follow IFQ_BYPASS_EN when the bench is built with it.

`ifndef TRAP_LEN
`define TRAP_LEN 16
`endif
`ifndef TRAP_INST_PAGE_FAULT
`define TRAP_INST_PAGE_FAULT 12
`endif

module tb_if_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_pc;
  logic [31:0]          in_inst;
  logic [`TRAP_LEN-1:0] in_trap;
  logic                 in_pdt_res;
  logic [31:0]          in_pdt_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_pc;
  logic [31:0]          out_inst;
  logic [`TRAP_LEN-1:0] out_trap;
  logic                 out_pdt_res;
  logic [31:0]          out_pdt_pc;
  logic                 if_flush;
  logic [PTR_W:0]       count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_inst_queue #(
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_pc_i       (in_pc),
    .in_inst_i     (in_inst),
    .in_trap_i     (in_trap),
    .in_pdt_res_i  (in_pdt_res),
    .in_pdt_pc_i   (in_pdt_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pc_o      (out_pc),
    .out_inst_o    (out_inst),
    .out_trap_o    (out_trap),
    .out_pdt_res_o (out_pdt_res),
    .out_pdt_pc_o  (out_pdt_pc),
    .if_flush_i    (if_flush),
    .count_o       (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [`TRAP_LEN-1:0] pf_bit;
    logic [31:0]          exp_pc;
    logic [31:0]          drain_pc [4];
    int                   pushed;
    int                   pops;
    int                   guard;

    pf_bit = '0;
    pf_bit[`TRAP_INST_PAGE_FAULT] = 1'b1;
    drain_pc[0] = 32'h8000_0004;
    drain_pc[1] = 32'h8000_0008;
    drain_pc[2] = 32'h8000_000C;
    drain_pc[3] = 32'h8000_0010;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_pc      = '0;
    in_inst    = '0;
    in_trap    = '0;
    in_pdt_res = 1'b0;
    in_pdt_pc  = '0;
    out_ready  = 1'b0;
    if_flush   = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_inst", {32'd0, out_inst}, 64'h13);
    check("rst_pc", {32'd0, out_pc}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_count", {61'd0, count}, 64'd0);

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'b1;
      in_pc      = 32'h8000_0000 + 32'(4 * i);
      in_inst    = 32'h100 + 32'(i);
      in_pdt_res = (i == 1);
      in_pdt_pc  = (i == 1) ? 32'h8000_0040 : 32'h0;
      #1 check("fill_ready", {63'd0, in_ready}, 64'd1);
      tick();
    end
    in_valid   = 1'b0;
    in_pdt_res = 1'b0;
    in_pdt_pc  = '0;
    #1;
    check("full_count", {61'd0, count}, 64'd4);
    check("full_ready", {63'd0, in_ready}, 64'd0);
    check("full_head_pc", {32'd0, out_pc}, 64'h8000_0000);
    check("full_head_inst", {32'd0, out_inst}, 64'h100);

    // Push while full together with a pop.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h8000_0010;
    in_inst   = 32'h104;
    #1 check("full_pop_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    #1 check("full_pp_count", {61'd0, count}, 64'd4);
    check("pdt_res_head", {63'd0, out_pdt_res}, 64'd1);
    check("pdt_pc_head", {32'd0, out_pdt_pc}, 64'h8000_0040);
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", {32'd0, out_pc}, {32'd0, drain_pc[k]});
      check("drain_ready", {63'd0, in_ready}, 64'd1);
      tick();
    end
    check("drained_count", {61'd0, count}, 64'd0);
    check("drained_valid", {63'd0, out_valid}, 64'd0);

    // Streaming across several pointer wraps.
    exp_pc = 32'h8000_0100;
    pushed = 0;
    pops   = 0;
    guard  = 0;
    while ((pushed < 3 * DEPTH || count != 0) && guard < 40) begin
      in_valid = (pushed < 3 * DEPTH);
      in_pc    = 32'h8000_0100 + 32'(4 * pushed);
      in_inst  = 32'h200 + 32'(pushed);
      #1;
      if (out_valid) begin
        check("stream_pc", {32'd0, out_pc}, {32'd0, exp_pc});
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (in_valid) begin
        check("stream_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready) pushed++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("stream_pops", 64'(pops), 64'(3 * DEPTH));
    check("stream_bound", {63'd0, guard < 40}, 64'd1);

    // Trapping entry blocks fetch until it pops.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h8000_1000;
    in_trap   = pf_bit;
    tick();
    in_pc   = 32'h8000_1004;
    in_trap = '0;
    #1;
    check("trap_ready", {63'd0, in_ready}, 64'd0);
    check("trap_head_pc", {32'd0, out_pc}, 64'h8000_1000);
    check("trap_head_bit", 64'(out_trap), 64'(pf_bit));
    tick();
    check("trap_count", {61'd0, count}, 64'd1);
    out_ready = 1'b1;
    #1 check("trap_pop_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("trap_cleared_ready", {63'd0, in_ready}, 64'd1);
`ifdef IFQ_BYPASS_EN
    check("post_trap_byp_valid", {63'd0, out_valid}, 64'd1);
    check("post_trap_byp_pc", {32'd0, out_pc}, 64'h8000_1004);
    check("post_trap_byp_trap", 64'(out_trap), 64'd0);
    tick();
    check("post_trap_byp_count", {61'd0, count}, 64'd0);
`else
    check("post_trap_count0", {61'd0, count}, 64'd0);
    tick();
    check("post_trap_count", {61'd0, count}, 64'd1);
    check("post_trap_pc", {32'd0, out_pc}, 64'h8000_1004);
    check("post_trap_trap", 64'(out_trap), 64'd0);
    in_valid = 1'b0;
    tick();
`endif
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 check("pre_flush_empty", {61'd0, count}, 64'd0);

    // Flush with three queued entries and a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h8000_3000 + 32'(4 * i);
      tick();
    end
    check("pre_flush_count", {61'd0, count}, 64'd3);
    in_pc    = 32'h8000_300C;
    if_flush = 1'b1;
    #1 check("flush_ready", {63'd0, in_ready}, 64'd0);
    tick();
    if_flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_count", {61'd0, count}, 64'd0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_inst", {32'd0, out_inst}, 64'h13);
    tick();
    check("flush_no_entry", {63'd0, out_valid}, 64'd0);

    // Entry arriving at an empty queue with decode ready.
    in_valid  = 1'b1;
    in_pc     = 32'h8000_2000;
    out_ready = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    check("byp_valid", {63'd0, out_valid}, 64'd1);
    check("byp_pc", {32'd0, out_pc}, 64'h8000_2000);
    tick();
    in_valid = 1'b0;
    #1 check("byp_count", {61'd0, count}, 64'd0);
`else
    check("nobyp_valid", {63'd0, out_valid}, 64'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("nobyp_count", {61'd0, count}, 64'd1);
    check("nobyp_pc", {32'd0, out_pc}, 64'h8000_2000);
    tick();
    check("nobyp_drained", {61'd0, count}, 64'd0);
`endif

    // Asynchronous reset in the middle of operation.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h8000_4000 + 32'(4 * i);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_count", {61'd0, count}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", {61'd0, count}, 64'd0);
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_inst", {32'd0, out_inst}, 64'h13);
    check("async_rst_ready", {63'd0, in_ready}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
